// File: rtl/hazard_control_if.sv
// Hazard control bundle: ID/EX hazard inputs and pipeline control outputs.
// The master side (pipeline or bench) drives hazard inputs; the slave side
// (hazard_control) drives stall/flush/hold controls and the performance counters.
interface hazard_control_if;
    logic [0:4]  IDRs1;
    logic [0:4]  IDRs2;
    logic        IDUsesRs2;
    logic        EXMemRead;
    logic        EXRegWrite;
    logic [0:4]  EXRd;
    logic        Redirect;
    logic        MulDivStart;
    logic        Stall;
    logic        EXBubble;
    logic        IDFlush;
    logic        EXHold;
    logic        MulDivDone;
    logic [0:31] StallCount;
    logic [0:31] FlushCount;

    modport master (
        output IDRs1, IDRs2, IDUsesRs2, EXMemRead, EXRegWrite, EXRd, Redirect, MulDivStart,
        input  Stall, EXBubble, IDFlush, EXHold, MulDivDone, StallCount, FlushCount
    );

    modport slave (
        input  IDRs1, IDRs2, IDUsesRs2, EXMemRead, EXRegWrite, EXRd, Redirect, MulDivStart,
        output Stall, EXBubble, IDFlush, EXHold, MulDivDone, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard control: load-use stall, branch redirect flush, and a
// multi-cycle multiply/divide busy sequencer, plus saturating stall/flush counters.
module hazard_control #(
    parameter int unsigned MD_CYCLES = 5
) (
    input logic              clk,
    input logic              reset,
    hazard_control_if.slave  bus
);

    typedef enum logic {StRun, StMdBusy} state_e;

    // Busy lasts MD_CYCLES cycles: counter runs MD_CYCLES-1 down to 0.
    localparam logic [3:0] CntInit = 4'(MD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [0:31] stall_count_q;
    logic [0:31] flush_count_q;

    logic load_use;
    logic stall;
    logic ex_bubble;
    logic id_flush;
    logic ex_hold;
    logic md_done;

    // Load in EX feeding a source register of ID; R0 never creates a hazard.
    always_comb begin
        load_use = bus.EXMemRead & bus.EXRegWrite & (bus.EXRd != 5'd0) &
                   ((bus.EXRd == bus.IDRs1) | (bus.IDUsesRs2 & (bus.EXRd == bus.IDRs2)));
    end

    // Next-state and control outputs; reset forces all controls low.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        ex_bubble = 1'b0;
        id_flush  = 1'b0;
        ex_hold   = 1'b0;
        md_done   = 1'b0;
        unique case (state_q)
            StRun: begin
                // Redirect wins over load-use: the stalled instruction is squashed anyway.
                if (bus.Redirect) begin
                    id_flush  = 1'b1;
                    ex_bubble = 1'b1;
                end else if (load_use) begin
                    stall     = 1'b1;
                    ex_bubble = 1'b1;
                end
                if (bus.MulDivStart) begin
                    state_d = StMdBusy;
                    cnt_d   = CntInit;
                end
            end
            StMdBusy: begin
                stall   = 1'b1;
                ex_hold = 1'b1;
                if (cnt_q == 4'd0) begin
                    md_done = 1'b1;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 4'd0;
            end
        endcase
        if (reset) begin
            stall     = 1'b0;
            ex_bubble = 1'b0;
            id_flush  = 1'b0;
            ex_hold   = 1'b0;
            md_done   = 1'b0;
        end
    end

    // State and down-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (id_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign bus.Stall      = stall;
    assign bus.EXBubble   = ex_bubble;
    assign bus.IDFlush    = id_flush;
    assign bus.EXHold     = ex_hold;
    assign bus.MulDivDone = md_done;
    assign bus.StallCount = stall_count_q;
    assign bus.FlushCount = flush_count_q;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: table of single-cycle RUN vectors,
// then hand-written multiply/divide, reset-abort and saturation sequences.
module tb_hazard_control;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] exp_stall_cnt;
    logic [31:0] exp_flush_cnt;

    hazard_control_if bus ();

    hazard_control #(.MD_CYCLES(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic       mem_read;
        logic       reg_write;
        logic [4:0] rd;
        logic       redirect;
        logic       stall;
        logic       bubble;
        logic       flush;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                         input logic mr, input logic rw, input logic [4:0] rd,
                         input logic redir, input logic mds);
        bus.IDRs1       = rs1;
        bus.IDRs2       = rs2;
        bus.IDUsesRs2   = uses;
        bus.EXMemRead   = mr;
        bus.EXRegWrite  = rw;
        bus.EXRd        = rd;
        bus.Redirect    = redir;
        bus.MulDivStart = mds;
    endtask

    task automatic check_ctl(input string name, input logic st, input logic bb, input logic fl,
                             input logic hd, input logic dn);
        check({name, ".Stall"}, {31'd0, bus.Stall}, {31'd0, st});
        check({name, ".EXBubble"}, {31'd0, bus.EXBubble}, {31'd0, bb});
        check({name, ".IDFlush"}, {31'd0, bus.IDFlush}, {31'd0, fl});
        check({name, ".EXHold"}, {31'd0, bus.EXHold}, {31'd0, hd});
        check({name, ".MulDivDone"}, {31'd0, bus.MulDivDone}, {31'd0, dn});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.StallCount", bus.StallCount, 32'd0);
        check("rst.FlushCount", bus.FlushCount, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        //            rs1   rs2  use mr  rw  rd    redir stall bub  flush
        vecs[0] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0};
        vecs[1] = '{5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 1, 1, 0};
        vecs[2] = '{5'd0, 5'd3, 1, 1, 1, 5'd0, 0, 0, 0, 0};
        vecs[3] = '{5'd1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, 0};
        vecs[4] = '{5'd1, 5'd7, 1, 1, 1, 5'd7, 0, 1, 1, 0};
        vecs[5] = '{5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 0, 0};
        vecs[6] = '{5'd5, 5'd0, 0, 1, 0, 5'd5, 0, 0, 0, 0};
        vecs[7] = '{5'd5, 5'd0, 0, 1, 1, 5'd5, 1, 0, 1, 1};
        vecs[8] = '{5'd2, 5'd3, 1, 0, 0, 5'd0, 1, 0, 1, 1};
        vecs[9] = '{5'd4, 5'd6, 1, 1, 1, 5'd5, 0, 0, 0, 0};

        // Controls held low while reset is high, even with every hazard present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        #1;
        check_ctl("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Single-cycle RUN vectors with a running counter model.
        exp_stall_cnt = 32'd0;
        exp_flush_cnt = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].uses_rs2, vecs[i].mem_read,
                  vecs[i].reg_write, vecs[i].rd, vecs[i].redirect, 1'b0);
            #1;
            check_ctl($sformatf("vec%0d", i), vecs[i].stall, vecs[i].bubble, vecs[i].flush,
                      1'b0, 1'b0);
            @(posedge clk);
            #1;
            if (vecs[i].stall) exp_stall_cnt = exp_stall_cnt + 32'd1;
            if (vecs[i].flush) exp_flush_cnt = exp_flush_cnt + 32'd1;
            check($sformatf("vec%0d.StallCount", i), bus.StallCount, exp_stall_cnt);
            check($sformatf("vec%0d.FlushCount", i), bus.FlushCount, exp_flush_cnt);
        end

        // Multiply/divide: start in T, busy T+1..T+5, Done only in T+5.
        do_reset();
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        check_ctl("md_T", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
            else if (k == 3) drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
            else drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            #1;
            check_ctl($sformatf("md_T+%0d", k), 1'b1, 1'b0, 1'b0, 1'b1, (k == 5));
        end
        // First RUN cycle after busy evaluates load-use normally.
        @(negedge clk);
        drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        check_ctl("md_T+6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("md.StallCount", bus.StallCount, 32'd6);
        check("md.FlushCount", bus.FlushCount, 32'd0);

        // Reset in the third cycle after start aborts the operation.
        do_reset();
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            #1;
            check_ctl($sformatf("abort_T+%0d", k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        #1;
        check_ctl("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            reset = 1'b0;
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            #1;
            check_ctl($sformatf("abort_T+%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("abort_T+%0d.StallCount", k), bus.StallCount, 32'd0);
        end

        // Saturation: preload near the top, hold load-use for three cycles.
        do_reset();
        @(negedge clk);
        dut.stall_count_q = 32'hFFFF_FFFE;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        check("sat.preload", bus.StallCount, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d.StallCount", k), bus.StallCount, 32'hFFFF_FFFF);
        end
        check("sat.FlushCount", bus.FlushCount, 32'd0);

        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
